// File: rtl/seq_ctrl.sv
// rtl/seq_ctrl.sv - multi-cycle instruction sequencer (fetch/decode/exec/mem/wb)
//
// Ports:
//   clk, rst_n            clock; asynchronous active-low reset
//   start                 leave IDLE (ignored in every other state)
//   opcode, instr_class   decoded instruction fields, sampled only in DECODE
//   cond_pass, en_status  condition result and S bit, sampled in DECODE
//   imem_ready/dmem_ready memory completion strobes
//   imem_req, dmem_req,   memory requests; dmem_we marks a store
//   dmem_we
//   load_ir, load_pc,     datapath enables
//   load_rf, link_wr,
//   load_status, sel_wb   sel_wb 0=ALU result, 1=memory data
//   sel_pc                PC source: 00 PC+4, 01 imm24 target, 10 register
//   state, halted         current state code, halt indication
//   retired_cnt           retired instruction count (wraps)
module seq_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [6:0]  opcode,
  input  logic [1:0]  instr_class,
  input  logic        cond_pass,
  input  logic        en_status,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  output logic        imem_req,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        load_ir,
  output logic        load_pc,
  output logic        load_rf,
  output logic        link_wr,
  output logic        load_status,
  output logic        sel_wb,
  output logic [1:0]  sel_pc,
  output logic [2:0]  state,
  output logic        halted,
  output logic [15:0] retired_cnt
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  typedef enum logic [2:0] {
    K_ALU    = 3'd0,
    K_BR_IMM = 3'd1,
    K_BR_REG = 3'd2,
    K_MEM    = 3'd3,
    K_HALT   = 3'd4
  } kind_t;

  state_t state_q, state_d;

  // Instruction attributes captured in DECODE; EXEC/MEM/WB look only at these.
  kind_t kind_q;
  logic  store_q;
  logic  link_q;
  logic  cmp_q;
  logic  ens_q;

  kind_t dec_kind;
  logic  dec_store;
  logic  dec_link;
  logic  dec_cmp;
  logic  retire;
  logic  is_load;

  // Classification of the instruction currently presented by the decoder.
  always_comb begin
    dec_kind  = K_ALU;
    dec_store = 1'b0;
    dec_link  = 1'b0;
    case (instr_class)
      2'b00: begin
        if (opcode == 7'b0000001 || opcode == 7'b0000111) begin
          dec_kind = K_HALT;
        end else if (opcode == 7'b1000001 || opcode == 7'b1000101) begin
          dec_kind = K_BR_REG;
          dec_link = (opcode == 7'b1000101);
        end else begin
          dec_kind = K_ALU;
        end
      end
      2'b01: begin
        dec_kind  = K_MEM;
        dec_store = (opcode[6:4] == 3'b111);
      end
      2'b10: begin
        dec_kind = K_BR_IMM;
        dec_link = (opcode == 7'b1000100);
      end
      default: dec_kind = K_HALT;
    endcase
    dec_cmp = (dec_kind == K_ALU) && opcode[3] && (opcode[2:0] == 3'b010);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kind_q  <= K_ALU;
      store_q <= 1'b0;
      link_q  <= 1'b0;
      cmp_q   <= 1'b0;
      ens_q   <= 1'b0;
    end else if (state_q == S_DECODE) begin
      kind_q  <= dec_kind;
      store_q <= dec_store;
      link_q  <= dec_link;
      cmp_q   <= dec_cmp;
      ens_q   <= en_status;
    end
  end

  // Held when nothing retires so the count only moves on a retire edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired_cnt <= 16'd0;
    end else if (retire) begin
      retired_cnt <= retired_cnt + 16'd1;
    end
  end

  assign is_load = (kind_q == K_MEM) && !store_q;
  assign state   = state_q;

  always_comb begin
    state_d     = state_q;
    imem_req    = 1'b0;
    dmem_req    = 1'b0;
    dmem_we     = 1'b0;
    load_ir     = 1'b0;
    load_pc     = 1'b0;
    load_rf     = 1'b0;
    link_wr     = 1'b0;
    load_status = 1'b0;
    sel_wb      = 1'b0;
    sel_pc      = 2'b00;
    halted      = 1'b0;
    retire      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
      end
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          load_ir = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        // A halting instruction stops regardless of its condition and never retires.
        if (dec_kind == K_HALT) begin
          state_d = S_HALT;
        end else if (!cond_pass) begin
          load_pc = 1'b1;
          retire  = 1'b1;
          state_d = S_FETCH;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        case (kind_q)
          K_BR_IMM: begin
            load_pc = 1'b1;
            sel_pc  = 2'b01;
            link_wr = link_q;
            retire  = 1'b1;
            state_d = S_FETCH;
          end
          K_BR_REG: begin
            load_pc = 1'b1;
            sel_pc  = 2'b10;
            link_wr = link_q;
            retire  = 1'b1;
            state_d = S_FETCH;
          end
          K_MEM:   state_d = S_MEM;
          default: state_d = S_WB;
        endcase
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = store_q;
        if (dmem_ready) begin
          if (store_q) begin
            load_pc = 1'b1;
            retire  = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        // CMP only updates flags; loads never touch flags.
        load_rf     = !cmp_q;
        sel_wb      = is_load;
        load_status = cmp_q ? 1'b1 : (is_load ? 1'b0 : ens_q);
        load_pc     = 1'b1;
        retire      = 1'b1;
        state_d     = S_FETCH;
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: doc/seq_ctrl.md
SEQ_CTRL -- requirements
Module: seq_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-003 SHALL have port start, input, 1, leaves IDLE when high.
REQ-004 SHALL have port opcode, input, 7, decoded opcode from the instruction decoder.
REQ-005 SHALL have port instr_class, input, 2, instr[27:26]: 00 data/BX, 01 load/store, 10 branch, 11 undefined.
REQ-006 SHALL have port cond_pass, input, 1, condition field satisfied by current flags.
REQ-007 SHALL have port en_status, input, 1, S bit from the decoder.
REQ-008 SHALL have ports imem_ready and dmem_ready, input, 1 each, memory completion strobes.
REQ-009 SHALL have ports imem_req, dmem_req and dmem_we, output, 1 each, memory requests; dmem_we is store.
REQ-010 SHALL have ports load_ir, load_pc, load_rf, link_wr, load_status and sel_wb, output, 1 each, datapath enables; sel_wb 0=ALU, 1=memory.
REQ-011 SHALL have port sel_pc, output, 2, PC source: 00 PC+4, 01 imm24 target, 10 register target.
REQ-012 SHALL have ports state, output, 3, current state; halted, output, 1; retired_cnt, output, 16, count of retired instructions.

Function
REQ-013 SHALL encode states as IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6; codes 7 SHALL go to IDLE next cycle.
REQ-014 IDLE: all enables 0; start=1 -> FETCH next cycle.
REQ-015 FETCH: imem_req=1 until imem_ready; the cycle imem_ready=1 SHALL assert load_ir and move to DECODE; no timeout.
REQ-016 DECODE (1 cycle): classify and latch kind, store, link, reg-target, CMP flags; later states SHALL use latched values only.
REQ-017 Classification: class 11, or class 00 with opcode 0000001/0000111 -> HALT kind; class 00 with opcode 1000001/1000101 -> register branch (link when 1000101); other class 00 -> ALU; class 10 -> immediate branch (link when opcode 1000100); class 01 -> memory, store when opcode[6:4]=111.
REQ-018 CMP SHALL be ALU kind with opcode[3]=1 and opcode[2:0]=010.
REQ-019 DECODE exits: HALT kind -> HALT (cond_pass ignored, no retire); else cond_pass=0 -> FETCH with load_pc=1, sel_pc=00, retire; else -> EXEC.
REQ-020 EXEC, ALU -> WB. Branch: load_pc=1, sel_pc=01 immediate or 10 register, link_wr=link flag, retire, -> FETCH. Memory -> MEM.
REQ-021 MEM: dmem_req=1, dmem_we=store flag, held until dmem_ready; on ready, store: load_pc=1, sel_pc=00, retire, -> FETCH; load -> WB.
REQ-022 WB (1 cycle): load_rf=1 except CMP; sel_wb=1 for load else 0; load_status = en_status latched at DECODE, forced 1 for CMP, 0 for loads; load_pc=1, sel_pc=00; retire; -> FETCH.
REQ-023 Retire SHALL increment retired_cnt by 1 same edge; 16'hFFFF wraps to 0.
REQ-024 HALT: halted=1, all other enables 0; SHALL remain until rst_n low; start ignored.
REQ-025 Outputs SHALL be combinational on state and latched flags; at most one of imem_req, dmem_req high in any cycle.
REQ-026 start in any state other than IDLE SHALL be ignored.

Reset
REQ-027 rst_n=0 SHALL immediately force state=IDLE, retired_cnt=0, all enables, requests, halted and sel_pc to 0, latched flags to 0, including mid-FETCH/MEM.
REQ-028 After rst_n rises, SHALL wait in IDLE for start.

Verification
REQ-029 start=1, imem_ready after 3 waits, class 00 opcode 0001000 (ADD imm), cond_pass=1, en_status=1 -> FETCH 4 cycles, DECODE, EXEC, WB with load_rf=1, load_status=1, sel_pc=00; retired_cnt=1.
REQ-030 LDR: class 01 opcode 1100100, dmem_ready after 2 waits -> dmem_req 3 cycles, dmem_we=0, WB sel_wb=1, load_rf=1, load_status=0; STR opcode 1110100 -> dmem_we=1, no WB, load_rf never 1.
REQ-031 BL class 10 opcode 1000100 -> EXEC load_pc=1, sel_pc=01, link_wr=1; BX class 00 opcode 1000001 -> sel_pc=10, link_wr=0.
REQ-032 cond_pass=0 on CMP -> DECODE straight to FETCH, load_pc=1, load_rf and load_status never 1, retired_cnt+1; cond_pass=1 CMP -> WB load_rf=0, load_status=1.
REQ-033 class 00 opcode 0000001 -> HALT, halted=1, retired_cnt unchanged, start pulses ignored; preset retired_cnt=16'hFFFF then one retire -> 0.
REQ-034 rst_n low during MEM with dmem_req=1 -> dmem_req=0 same cycle, state=IDLE, retired_cnt=0.
